cell_shifter_pipe: RTL



---
 rtl/cell_pkg.sv | 18 +
 rtl/shift_stage.sv | 39 +++
 rtl/cell_shifter_pipe.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cell_pkg.sv
// cell_pkg: shared opcode definitions for the CLB cells.
//   OP_W         opcode width
//   OP_SLL..ROR  operation codes; 6 and 7 are reserved
//   op_right()   true for the right-moving operations (SRL, SRA, ROR)
package cell_pkg;
  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_SLL = 3'd0;
  localparam logic [OP_W-1:0] OP_SRL = 3'd1;
  localparam logic [OP_W-1:0] OP_SRA = 3'd2;
  localparam logic [OP_W-1:0] OP_XOR = 3'd3;
  localparam logic [OP_W-1:0] OP_ROL = 3'd4;
  localparam logic [OP_W-1:0] OP_ROR = 3'd5;

  function automatic logic op_right(input logic [OP_W-1:0] op);
    return (op == OP_SRL) || (op == OP_SRA) || (op == OP_ROR);
  endfunction
endpackage

// File: rtl/shift_stage.sv
// shift_stage: a slice of a barrel shifter covering levels
// FIRST_LVL .. FIRST_LVL+NUM_LVL-1 (level k moves by 2**k bits).
//   din        data entering this slice
//   amt        the shamt bits that belong to this slice's levels
//   dir_right  1 = move towards LSB, 0 = towards MSB
//   fill       bit shifted in at the MSB on right shifts (sign for SRA)
//   rot        wrap shifted-out bits around instead of filling
//   dout       data leaving this slice
module shift_stage #(
  parameter int WIDTH     = 32,
  parameter int FIRST_LVL = 0,
  parameter int NUM_LVL   = 1
) (
  input  logic [WIDTH-1:0]   din,
  input  logic [NUM_LVL-1:0] amt,
  input  logic               dir_right,
  input  logic               fill,
  input  logic               rot,
  output logic [WIDTH-1:0]   dout
);
  logic [WIDTH-1:0] d;
  int               sh;

  always_comb begin
    d  = din;
    sh = 0;
    for (int i = 0; i < NUM_LVL; i++) begin
      if (amt[i]) begin
        sh = 1 << (FIRST_LVL + i);
        if (dir_right)
          d = rot ? ((d >> sh) | (d << (WIDTH - sh)))
                  : ((d >> sh) | (fill ? ~({WIDTH{1'b1}} >> sh) : '0));
        else
          d = rot ? ((d << sh) | (d >> (WIDTH - sh))) : (d << sh);
      end
    end
    dout = d;
  end
endmodule

// File: rtl/cell_shifter_pipe.sv
// cell_shifter_pipe: two-stage valid/ready shift/rotate/XOR/bypass cell.
//   clk, rst              clock, synchronous active-high reset
//   in_bus, sel0, sel1    NUM_IN candidate operands and their selects
//   sel_op, by_pass       operation code, pass-operand0-through override
//   in_valid / in_ready   request handshake
//   out_data, out_illegal result and reserved-opcode flag
//   out_valid / out_ready result handshake
// Build option: CELL_SHIFT_ROTATE_EN enables ROL/ROR; when undefined
// opcodes 4 and 5 are reported as reserved.
module cell_shifter_pipe
  import cell_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SELW   = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SELW-1:0]         sel0,
  input  logic [SELW-1:0]         sel1,
  input  logic [OP_W-1:0]         sel_op,
  input  logic                    by_pass,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_illegal,
  output logic                    out_valid,
  input  logic                    out_ready
);
  localparam int SHW    = $clog2(WIDTH);
  localparam int S1_LVL = SHW / 2;
  localparam int S2_LVL = SHW - S1_LVL;

`ifdef CELL_SHIFT_ROTATE_EN
  localparam logic ROT_EN = 1'b1;
`else
  localparam logic ROT_EN = 1'b0;
`endif

  function automatic logic op_rot(input logic [OP_W-1:0] op);
    return ROT_EN && ((op == OP_ROL) || (op == OP_ROR));
  endfunction

  function automatic logic op_rsv(input logic [OP_W-1:0] op);
    return ROT_EN ? (op > OP_ROR) : (op > OP_XOR);
  endfunction

  // S1 state
  logic [WIDTH-1:0] op0_q, op0_d, op1_q, op1_d, part_q, part_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic             byp_q, byp_d, s1_v_q, s1_v_d;
  // S2 state
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_illegal_q, out_illegal_d, s2_v_q, s2_v_d;

  logic [WIDTH-1:0] opa, opb, part_sh, full_sh, res;
  logic             ill, s1_adv, s2_adv;

  // Out-of-range selects match no candidate and leave the operand at 0.
  always_comb begin
    opa = '0;
    opb = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (int'(sel0) == k) opa = in_bus[k*WIDTH +: WIDTH];
      if (int'(sel1) == k) opb = in_bus[k*WIDTH +: WIDTH];
    end
  end

  shift_stage #(.WIDTH(WIDTH), .FIRST_LVL(0), .NUM_LVL(S1_LVL)) u_s1_shift (
    .din       (opa),
    .amt       (opb[0 +: S1_LVL]),
    .dir_right (op_right(sel_op)),
    .fill      (opa[WIDTH-1] && (sel_op == OP_SRA)),
    .rot       (op_rot(sel_op)),
    .dout      (part_sh)
  );

  shift_stage #(.WIDTH(WIDTH), .FIRST_LVL(S1_LVL), .NUM_LVL(S2_LVL)) u_s2_shift (
    .din       (part_q),
    .amt       (op1_q[S1_LVL +: S2_LVL]),
    .dir_right (op_right(op_q)),
    .fill      (op0_q[WIDTH-1] && (op_q == OP_SRA)),
    .rot       (op_rot(op_q)),
    .dout      (full_sh)
  );

  always_comb begin
    s2_adv   = !s2_v_q || out_ready;
    s1_adv   = !s1_v_q || s2_adv;
    in_ready = s1_adv && !rst;

    ill = !byp_q && op_rsv(op_q);
    if (byp_q)              res = op0_q;
    else if (ill)           res = '0;
    else if (op_q == OP_XOR) res = op0_q ^ op1_q;
    else                    res = full_sh;

    op0_d  = op0_q;
    op1_d  = op1_q;
    op_d   = op_q;
    byp_d  = byp_q;
    part_d = part_q;
    s1_v_d = s1_v_q;
    if (s1_adv) begin
      op0_d  = opa;
      op1_d  = opb;
      op_d   = sel_op;
      byp_d  = by_pass;
      part_d = part_sh;
      s1_v_d = in_valid;
    end

    out_data_d    = out_data_q;
    out_illegal_d = out_illegal_q;
    s2_v_d        = s2_v_q;
    if (s2_adv) begin
      out_data_d    = res;
      out_illegal_d = ill;
      s2_v_d        = s1_v_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op0_q         <= '0;
      op1_q         <= '0;
      op_q          <= '0;
      byp_q         <= 1'b0;
      part_q        <= '0;
      s1_v_q        <= 1'b0;
      out_data_q    <= '0;
      out_illegal_q <= 1'b0;
      s2_v_q        <= 1'b0;
    end else begin
      op0_q         <= op0_d;
      op1_q         <= op1_d;
      op_q          <= op_d;
      byp_q         <= byp_d;
      part_q        <= part_d;
      s1_v_q        <= s1_v_d;
      out_data_q    <= out_data_d;
      out_illegal_q <= out_illegal_d;
      s2_v_q        <= s2_v_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_illegal = out_illegal_q;
  assign out_valid   = s2_v_q;
endmodule
